// File: rtl/myspi_master_if.sv
// Request/response bus between on-chip logic and the SPI register master.
// The requester uses the master modport; myspi_master uses the slave modport.
interface myspi_master_if;
    logic        start;
    logic        wr;
    logic [14:0] addr;
    logic [15:0] wdata;
    logic        busy;
    logic        done;
    logic [15:0] rdata;

    modport master (
        output start, wr, addr, wdata,
        input  busy, done, rdata
    );

    modport slave (
        input  start, wr, addr, wdata,
        output busy, done, rdata
    );
endinterface

// File: rtl/myspi_master.sv
// SPI master issuing 32-bit register frames (command/address word, then data word),
// mode 0, MSB first; every output comes straight from a flop.
module myspi_master #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    parameter int CS_IDLE  = 4
) (
    input  logic          theClock,
    input  logic          theReset,
    myspi_master_if.slave bus,
    output logic          MySPI_cs,
    output logic          MySPI_clk,
    output logic          MySPI_sdo,
    input  logic          MySPI_sdi
);

    localparam int MAX_AB  = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int MAX_CD  = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
    localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(CS_IDLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        HOLD,
        GAP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       bit_q, bit_d;
    logic             last_q, last_d;
    logic [31:0]      tx_q, tx_d;
    logic [15:0]      rx_q, rx_d;
    logic [15:0]      rdata_q, rdata_d;
    logic             cs_q, cs_d;
    logic             sclk_q, sclk_d;
    logic             sdo_q, sdo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_ff @(posedge theClock or negedge theReset) begin
        if (!theReset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            last_q  <= 1'b0;
            tx_q    <= '0;
            rx_q    <= '0;
            rdata_q <= '0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
            sdo_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            last_q  <= last_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
            cs_q    <= cs_d;
            sclk_q  <= sclk_d;
            sdo_q   <= sdo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        bit_d   = bit_q;
        last_d  = last_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.start) begin
                    tx_d    = {bus.wr, bus.addr, bus.wdata};
                    rx_d    = '0;
                    bit_d   = '0;
                    last_d  = 1'b0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    last_d  = (bit_q == 5'd31);
                    state_d = LOW;
                end
            end
            LOW: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    state_d = last_q ? HOLD : HIGH;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    rdata_d = rx_q;
                    done_d  = 1'b1;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (cnt_q == IDLE_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        // MISO is taken on the edge that raises SCLK, and only for the data word.
        if (state_d == HIGH && state_q != HIGH && bit_q[4]) begin
            rx_d = {rx_q[14:0], MySPI_sdi};
        end

        // The falling edge advances MOSI; the counter parks at 31 so it never wraps.
        if (state_d == LOW && state_q != LOW) begin
            tx_d  = {tx_q[30:0], 1'b0};
            bit_d = (bit_q == 5'd31) ? bit_q : bit_q + 5'd1;
        end

        cs_d   = !(state_d inside {SETUP, HIGH, LOW, HOLD});
        sclk_d = (state_d == HIGH);
        sdo_d  = cs_d ? 1'b0 : tx_d[31];
        busy_d = (state_d != IDLE);
    end

    assign MySPI_cs  = cs_q;
    assign MySPI_clk = sclk_q;
    assign MySPI_sdo = sdo_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_myspi_master.sv
// Bench for myspi_master: a register-file slave model on the pins, a scoreboard of
// expected frames/read words, and one task per scenario.
module tb_myspi_master;

    logic theClock = 1'b0;
    logic theReset = 1'b1;
    always #5 theClock = ~theClock;

    myspi_master_if bus ();
    myspi_master_if bus6 ();

    logic spi_cs, spi_clk, spi_sdo;
    logic spi_sdi = 1'b0;
    logic cs6, clk6, sdo6;
    logic sdi6 = 1'b0;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] frame;
        logic [15:0] rdata;
    } exp_t;

    exp_t sb [$];
    logic [15:0] exp_regs [16] = '{1: 16'h00A5, default: 16'h0000};
    logic [15:0] slave_regs [16] = '{1: 16'h00A5, default: 16'h0000};

    myspi_master dut (
        .theClock (theClock),
        .theReset (theReset),
        .bus      (bus),
        .MySPI_cs (spi_cs),
        .MySPI_clk(spi_clk),
        .MySPI_sdo(spi_sdo),
        .MySPI_sdi(spi_sdi)
    );

    myspi_master #(.CLK_DIV(6), .CS_SETUP(2)) dut6 (
        .theClock (theClock),
        .theReset (theReset),
        .bus      (bus6),
        .MySPI_cs (cs6),
        .MySPI_clk(clk6),
        .MySPI_sdo(sdo6),
        .MySPI_sdi(sdi6)
    );

    // Register-file slave: samples MOSI on SCLK rise, shifts MISO on SCLK fall,
    // commits a complete write frame when CS returns high.
    logic        s_clk_d = 1'b0;
    logic        s_cs_d  = 1'b1;
    int          s_cnt   = 0;
    logic [31:0] s_rx    = '0;
    logic [15:0] s_tx    = '0;

    always @(posedge theClock) begin
        s_clk_d <= spi_clk;
        s_cs_d  <= spi_cs;
        if (spi_cs) begin
            if (!s_cs_d && s_cnt == 32 && s_rx[31]) slave_regs[s_rx[19:16]] <= s_rx[15:0];
            s_cnt   <= 0;
            spi_sdi <= 1'b0;
        end else begin
            if (spi_clk && !s_clk_d) begin
                s_rx  <= {s_rx[30:0], spi_sdo};
                s_cnt <= s_cnt + 1;
            end
            if (!spi_clk && s_clk_d) begin
                if (s_cnt == 16) begin
                    spi_sdi <= slave_regs[s_rx[3:0]][15];
                    s_tx    <= {slave_regs[s_rx[3:0]][14:0], 1'b0};
                end else if (s_cnt > 16) begin
                    spi_sdi <= s_tx[15];
                    s_tx    <= {s_tx[14:0], 1'b0};
                end
            end
        end
    end

    // Second slave answers every read with a fixed word.
    localparam logic [15:0] PAT6 = 16'hC3A5;
    logic        s6_clk_d = 1'b0;
    int          s6_cnt   = 0;
    logic [15:0] s6_tx    = '0;

    always @(posedge theClock) begin
        s6_clk_d <= clk6;
        if (cs6) begin
            s6_cnt <= 0;
            sdi6   <= 1'b0;
        end else begin
            if (clk6 && !s6_clk_d) s6_cnt <= s6_cnt + 1;
            if (!clk6 && s6_clk_d) begin
                if (s6_cnt == 16) begin
                    sdi6  <= PAT6[15];
                    s6_tx <= {PAT6[14:0], 1'b0};
                end else if (s6_cnt > 16) begin
                    sdi6  <= s6_tx[15];
                    s6_tx <= {s6_tx[14:0], 1'b0};
                end
            end
        end
    end

    task automatic push_exp(input logic w, input logic [14:0] a, input logic [15:0] d);
        exp_t e;
        e.frame = {w, a, d};
        e.rdata = exp_regs[a[3:0]];
        sb.push_back(e);
        if (w) exp_regs[a[3:0]] = d;
    endtask

    // Issues one frame on the default instance and measures it up to the done pulse.
    task automatic run_frame(input logic w, input logic [14:0] a, input logic [15:0] d,
                             output int done_cyc, output int rises, output int unstable,
                             output logic [31:0] mosi,
                             output logic c1_cs, output logic c1_busy, output logic c1_sdo);
        int   n;
        logic prev_clk, prev_sdo;
        for (int k = 0; k < 20 && bus.busy === 1'b1; k++) @(negedge theClock);
        @(negedge theClock);
        bus.start = 1'b1;
        bus.wr    = w;
        bus.addr  = a;
        bus.wdata = d;
        push_exp(w, a, d);
        @(negedge theClock);
        bus.start = 1'b0;
        n        = 1;
        c1_cs    = spi_cs;
        c1_busy  = bus.busy;
        c1_sdo   = spi_sdo;
        rises    = 0;
        unstable = 0;
        mosi     = '0;
        prev_clk = spi_clk;
        prev_sdo = spi_sdo;
        while (bus.done !== 1'b1 && n < 1000) begin
            @(negedge theClock);
            n++;
            if (spi_clk && !prev_clk) begin
                rises++;
                mosi = {mosi[30:0], spi_sdo};
            end
            if (spi_clk && prev_clk && spi_sdo !== prev_sdo) unstable++;
            prev_clk = spi_clk;
            prev_sdo = spi_sdo;
        end
        done_cyc = (bus.done === 1'b1) ? n : -1;
    endtask

    task automatic test_reset();
        bus.start  = 1'b0;
        bus.wr     = 1'b0;
        bus.addr   = '0;
        bus.wdata  = '0;
        bus6.start = 1'b0;
        bus6.wr    = 1'b0;
        bus6.addr  = '0;
        bus6.wdata = '0;
        theReset   = 1'b0;
        repeat (2) @(negedge theClock);
        checks++; if (spi_cs !== 1'b1) begin errors++; $display("[TB] FAIL reset_cs: got %b expected 1", spi_cs); end
        checks++; if (spi_clk !== 1'b0) begin errors++; $display("[TB] FAIL reset_sclk: got %b expected 0", spi_clk); end
        checks++; if (spi_sdo !== 1'b0) begin errors++; $display("[TB] FAIL reset_sdo: got %b expected 0", spi_sdo); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", bus.done); end
        checks++; if (bus.rdata !== 16'h0000) begin errors++; $display("[TB] FAIL reset_rdata: got %h expected 0000", bus.rdata); end
        checks++; if (cs6 !== 1'b1) begin errors++; $display("[TB] FAIL reset_cs6: got %b expected 1", cs6); end
        theReset = 1'b1;
        repeat (2) @(negedge theClock);
    endtask

    task automatic test_read();
        int dc, ri, us;
        logic [31:0] mo;
        logic c1, b1, s1;
        exp_t e;
        run_frame(1'b0, 15'h0001, 16'h1234, dc, ri, us, mo, c1, b1, s1);
        e = sb.pop_front();
        checks++; if (c1 !== 1'b0) begin errors++; $display("[TB] FAIL read_cs_cycle1: got %b expected 0", c1); end
        checks++; if (b1 !== 1'b1) begin errors++; $display("[TB] FAIL read_busy_cycle1: got %b expected 1", b1); end
        checks++; if (s1 !== 1'b0) begin errors++; $display("[TB] FAIL read_sdo_cycle1: got %b expected 0", s1); end
        checks++; if (dc != 265) begin errors++; $display("[TB] FAIL read_done_cycle: got %0d expected 265", dc); end
        checks++; if (ri != 32) begin errors++; $display("[TB] FAIL read_sclk_rises: got %0d expected 32", ri); end
        checks++; if (us != 0) begin errors++; $display("[TB] FAIL read_mosi_stable: got %0d changes expected 0", us); end
        checks++; if (mo !== e.frame) begin errors++; $display("[TB] FAIL read_mosi_frame: got %h expected %h", mo, e.frame); end
        checks++; if (bus.rdata !== e.rdata) begin errors++; $display("[TB] FAIL read_rdata: got %h expected %h", bus.rdata, e.rdata); end
        checks++; if (spi_cs !== 1'b1) begin errors++; $display("[TB] FAIL read_cs_at_done: got %b expected 1", spi_cs); end
        @(negedge theClock);
        checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL read_done_width: got %b expected 0", bus.done); end
    endtask

    task automatic test_write();
        int dc, ri, us;
        logic [31:0] mo;
        logic c1, b1, s1;
        exp_t e;
        run_frame(1'b1, 15'h0000, 16'h0042, dc, ri, us, mo, c1, b1, s1);
        e = sb.pop_front();
        checks++; if (s1 !== 1'b1) begin errors++; $display("[TB] FAIL write_sdo_cycle1: got %b expected 1", s1); end
        checks++; if (dc != 265) begin errors++; $display("[TB] FAIL write_done_cycle: got %0d expected 265", dc); end
        checks++; if (mo !== e.frame) begin errors++; $display("[TB] FAIL write_mosi_frame: got %h expected %h", mo, e.frame); end
        checks++; if (bus.rdata !== e.rdata) begin errors++; $display("[TB] FAIL write_rdata_old: got %h expected %h", bus.rdata, e.rdata); end
        repeat (3) @(negedge theClock);
        checks++; if (slave_regs[0] !== 16'h0042) begin errors++; $display("[TB] FAIL write_slave_config: got %h expected 0042", slave_regs[0]); end
        run_frame(1'b0, 15'h0000, 16'h0000, dc, ri, us, mo, c1, b1, s1);
        e = sb.pop_front();
        checks++; if (dc != 265) begin errors++; $display("[TB] FAIL readback_done_cycle: got %0d expected 265", dc); end
        checks++; if (bus.rdata !== e.rdata) begin errors++; $display("[TB] FAIL readback_rdata: got %h expected %h", bus.rdata, e.rdata); end
    endtask

    task automatic test_start_while_busy();
        int n, dones, done_at;
        exp_t e;
        for (int k = 0; k < 20 && bus.busy === 1'b1; k++) @(negedge theClock);
        @(negedge theClock);
        bus.start = 1'b1;
        bus.wr    = 1'b0;
        bus.addr  = 15'h0001;
        bus.wdata = 16'hBEEF;
        push_exp(1'b0, 15'h0001, 16'hBEEF);
        n       = 0;
        dones   = 0;
        done_at = -1;
        while (n < 320) begin
            @(negedge theClock);
            n++;
            if (n == 1) bus.start = 1'b0;
            if (n == 95) begin
                bus.start = 1'b1;
                bus.wr    = 1'b1;
                bus.addr  = 15'h0000;
                bus.wdata = 16'hDEAD;
            end
            if (n == 96) bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                dones++;
                done_at = n;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    checks++; if (bus.rdata !== e.rdata) begin errors++; $display("[TB] FAIL busy_start_rdata: got %h expected %h", bus.rdata, e.rdata); end
                end
            end
        end
        checks++; if (dones != 1) begin errors++; $display("[TB] FAIL busy_start_done_count: got %0d expected 1", dones); end
        checks++; if (done_at != 265) begin errors++; $display("[TB] FAIL busy_start_done_cycle: got %0d expected 265", done_at); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL busy_start_not_queued: got busy=%b expected 0", bus.busy); end
        checks++; if (slave_regs[0] !== exp_regs[0]) begin errors++; $display("[TB] FAIL busy_start_no_write: got %h expected %h", slave_regs[0], exp_regs[0]); end
    endtask

    task automatic test_reset_mid_frame();
        int n, dones, dc, ri, us;
        logic [31:0] mo;
        logic c1, b1, s1;
        exp_t e;
        for (int k = 0; k < 20 && bus.busy === 1'b1; k++) @(negedge theClock);
        @(negedge theClock);
        bus.start = 1'b1;
        bus.wr    = 1'b0;
        bus.addr  = 15'h0001;
        bus.wdata = 16'h0000;
        n     = 0;
        dones = 0;
        while (n < 120) begin
            @(negedge theClock);
            n++;
            if (n == 1) bus.start = 1'b0;
            if (bus.done === 1'b1) dones++;
        end
        theReset = 1'b0;
        #1;
        checks++; if (spi_cs !== 1'b1) begin errors++; $display("[TB] FAIL midreset_cs: got %b expected 1", spi_cs); end
        checks++; if (spi_clk !== 1'b0) begin errors++; $display("[TB] FAIL midreset_sclk: got %b expected 0", spi_clk); end
        checks++; if (spi_sdo !== 1'b0) begin errors++; $display("[TB] FAIL midreset_sdo: got %b expected 0", spi_sdo); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.rdata !== 16'h0000) begin errors++; $display("[TB] FAIL midreset_rdata: got %h expected 0000", bus.rdata); end
        repeat (4) @(negedge theClock);
        theReset = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge theClock);
            if (bus.done === 1'b1) dones++;
        end
        checks++; if (dones != 0) begin errors++; $display("[TB] FAIL midreset_no_done: got %0d expected 0", dones); end
        run_frame(1'b0, 15'h0001, 16'h0000, dc, ri, us, mo, c1, b1, s1);
        e = sb.pop_front();
        checks++; if (dc != 265) begin errors++; $display("[TB] FAIL midreset_recover_cycle: got %0d expected 265", dc); end
        checks++; if (bus.rdata !== e.rdata) begin errors++; $display("[TB] FAIL midreset_recover_rdata: got %h expected %h", bus.rdata, e.rdata); end
    endtask

    task automatic test_back_to_back();
        int n, dones, first_done, second_done, cs_high;
        exp_t e;
        for (int k = 0; k < 20 && bus.busy === 1'b1; k++) @(negedge theClock);
        @(negedge theClock);
        bus.start = 1'b1;
        bus.wr    = 1'b0;
        bus.addr  = 15'h0001;
        bus.wdata = 16'h7777;
        push_exp(1'b0, 15'h0001, 16'h7777);
        push_exp(1'b0, 15'h0001, 16'h7777);
        n           = 0;
        dones       = 0;
        first_done  = -1;
        second_done = -1;
        cs_high     = 0;
        while (n < 600) begin
            @(negedge theClock);
            n++;
            if (n == 270) bus.start = 1'b0;
            if (first_done > 0 && second_done < 0 && spi_cs === 1'b1 && bus.done !== 1'b1) cs_high++;
            if (bus.done === 1'b1) begin
                dones++;
                if (first_done < 0) begin
                    first_done = n;
                    cs_high    = 1;
                end else if (second_done < 0) begin
                    second_done = n;
                end
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    checks++; if (bus.rdata !== e.rdata) begin errors++; $display("[TB] FAIL b2b_rdata: got %h expected %h", bus.rdata, e.rdata); end
                end
            end
        end
        checks++; if (dones != 2) begin errors++; $display("[TB] FAIL b2b_done_count: got %0d expected 2", dones); end
        checks++; if (first_done != 265) begin errors++; $display("[TB] FAIL b2b_first_done: got %0d expected 265", first_done); end
        checks++; if (second_done != 534) begin errors++; $display("[TB] FAIL b2b_second_done: got %0d expected 534", second_done); end
        checks++; if (cs_high != 5) begin errors++; $display("[TB] FAIL b2b_cs_gap: got %0d expected 5", cs_high); end
    endtask

    task automatic test_clk_div6();
        int n, rises, unstable, bad_high, bad_low, high_runs, low_runs, cur_high, cur_low, dc;
        logic prev_clk, prev_sdo, seen_rise;
        logic [31:0] mo;
        exp_t e, got;
        @(negedge theClock);
        bus6.start = 1'b1;
        bus6.wr    = 1'b0;
        bus6.addr  = 15'h0123;
        bus6.wdata = 16'h5555;
        e.frame = {1'b0, 15'h0123, 16'h5555};
        e.rdata = PAT6;
        sb.push_back(e);
        @(negedge theClock);
        bus6.start = 1'b0;
        checks++; if (cs6 !== 1'b0) begin errors++; $display("[TB] FAIL div6_cs_cycle1: got %b expected 0", cs6); end
        n = 1; rises = 0; unstable = 0; bad_high = 0; bad_low = 0;
        high_runs = 0; low_runs = 0; cur_high = 0; cur_low = 0;
        seen_rise = 1'b0;
        mo        = '0;
        prev_clk  = clk6;
        prev_sdo  = sdo6;
        while (bus6.done !== 1'b1 && n < 1000) begin
            @(negedge theClock);
            n++;
            if (clk6) cur_high++;
            else if (seen_rise) cur_low++;
            if (clk6 && !prev_clk) begin
                rises++;
                mo = {mo[30:0], sdo6};
                if (seen_rise) begin
                    low_runs++;
                    if (cur_low != 6) bad_low++;
                end
                seen_rise = 1'b1;
                cur_low   = 0;
            end
            if (!clk6 && prev_clk) begin
                high_runs++;
                if (cur_high != 6) bad_high++;
                cur_high = 0;
            end
            if (clk6 && prev_clk && sdo6 !== prev_sdo) unstable++;
            prev_clk = clk6;
            prev_sdo = sdo6;
        end
        dc  = (bus6.done === 1'b1) ? n : -1;
        got = sb.pop_front();
        checks++; if (dc != 391) begin errors++; $display("[TB] FAIL div6_done_cycle: got %0d expected 391", dc); end
        checks++; if (rises != 32) begin errors++; $display("[TB] FAIL div6_sclk_rises: got %0d expected 32", rises); end
        checks++; if (high_runs != 32 || bad_high != 0) begin errors++; $display("[TB] FAIL div6_high_phase: got %0d runs %0d bad expected 32 runs 0 bad", high_runs, bad_high); end
        checks++; if (low_runs != 31 || bad_low != 0) begin errors++; $display("[TB] FAIL div6_low_phase: got %0d runs %0d bad expected 31 runs 0 bad", low_runs, bad_low); end
        checks++; if (unstable != 0) begin errors++; $display("[TB] FAIL div6_mosi_stable: got %0d changes expected 0", unstable); end
        checks++; if (mo !== got.frame) begin errors++; $display("[TB] FAIL div6_mosi_frame: got %h expected %h", mo, got.frame); end
        checks++; if (bus6.rdata !== got.rdata) begin errors++; $display("[TB] FAIL div6_rdata: got %h expected %h", bus6.rdata, got.rdata); end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_read();
        test_write();
        test_start_while_busy();
        test_reset_mid_frame();
        test_back_to_back();
        test_clk_div6();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
